// File: rtl/cdma_despreader.sv
// Gold-code CDMA despreader: regenerates the 31-chip code from a shared seed,
// correlates each code period and acquires/tracks code phase by slipping.
module cdma_despreader #(
  parameter int CODE_LEN  = 31,
  parameter int HIT_THR   = 27,
  parameter int LO_THR    = 4,
  parameter int LOCK_HITS = 2,
  parameter int MISS_MAX  = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] seed_i,
  input  logic       chip_i,
  input  logic       chip_valid_i,
  output logic       bit_o,
  output logic       bit_valid_o,
  output logic       locked_o,
  output logic [4:0] corr_o,
  output logic       seed_err_o,
  output logic [1:0] state_o
);

  localparam int HW = $clog2(LOCK_HITS + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [4:0]    LAST_CHIP = 5'(CODE_LEN - 1);
  localparam logic [4:0]    HIT_T     = 5'(HIT_THR);
  localparam logic [4:0]    LO_T      = 5'(LO_THR);
  localparam logic [4:0]    MAJ_T     = 5'd16;
  localparam logic [HW-1:0] LOCK_LAST = HW'(LOCK_HITS - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, TRACK = 2'd2} state_t;

  state_t        state, state_nx;
  logic [4:0]    lfsr_a, lfsr_b;
  logic [4:0]    acc, cnt, total;
  logic [HW-1:0] hit_cnt, hit_nx;
  logic [MW-1:0] miss_cnt, miss_nx;
  logic          gold, active, last, hit_hi, hit;
  logic          slip, emit, emit_bit;

  assign state_o = state;

  // chip_valid_i qualifies chip_i for one cycle; there is no back-pressure,
  // and cycles without it leave every register (including code phase) untouched.
  assign gold   = lfsr_a[4] ^ lfsr_b[4];
  assign active = chip_valid_i && (state != IDLE);
  assign last   = active && (cnt == LAST_CHIP);
  assign total  = acc + {4'd0, chip_i ^ gold};
  assign hit_hi = (total >= HIT_T);
  assign hit    = hit_hi || (total <= LO_T);

  always_comb begin
    state_nx = state;
    hit_nx   = hit_cnt;
    miss_nx  = miss_cnt;
    slip     = 1'b0;
    emit     = 1'b0;
    emit_bit = hit ? hit_hi : (total >= MAJ_T);
    case (state)
      SEARCH: begin
        if (last) begin
          if (hit) begin
            if (hit_cnt == LOCK_LAST) begin
              state_nx = TRACK;
              hit_nx   = '0;
              miss_nx  = '0;
              emit     = 1'b1;
            end else begin
              hit_nx = hit_cnt + HW'(1);
            end
          end else begin
            // Holding the generator for one chip retards local code phase.
            hit_nx = '0;
            slip   = 1'b1;
          end
        end
      end
      TRACK: begin
        if (last) begin
          emit = 1'b1;
          if (hit) begin
            miss_nx = '0;
          end else if (miss_cnt == MISS_LAST) begin
            state_nx = SEARCH;
            hit_nx   = '0;
            miss_nx  = '0;
          end else begin
            miss_nx = miss_cnt + MW'(1);
          end
        end
      end
      IDLE:    state_nx = IDLE;
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= (seed_i == 5'd0) ? IDLE : SEARCH;
      lfsr_a      <= seed_i;
      lfsr_b      <= seed_i;
      acc         <= '0;
      cnt         <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
      locked_o    <= 1'b0;
      corr_o      <= '0;
      seed_err_o  <= (seed_i == 5'd0);
    end else begin
      state       <= state_nx;
      hit_cnt     <= hit_nx;
      miss_cnt    <= miss_nx;
      bit_valid_o <= emit;
      locked_o    <= (state_nx == TRACK);
      if (emit) bit_o <= emit_bit;
      if (active) begin
        if (!slip) begin
          lfsr_a <= {lfsr_a[3:0], lfsr_a[4] ^ lfsr_a[3] ^ lfsr_a[2] ^ lfsr_a[1]};
          lfsr_b <= {lfsr_b[3:0], lfsr_b[4] ^ lfsr_b[1]};
        end
        if (last) begin
          acc    <= '0;
          cnt    <= '0;
          corr_o <= total;
        end else begin
          acc <= total;
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdma_despreader.sv
// Bench for cdma_despreader: a period-level behavioural model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_cdma_despreader;

  localparam logic [4:0] TX_SEED = 5'b10101;
  localparam int M_IDLE = 0, M_SEARCH = 1, M_TRACK = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] seed = TX_SEED;
  logic       chip = 1'b0;
  logic       chip_valid = 1'b0;
  logic       bit_o, bit_valid_o, locked_o, seed_err_o;
  logic [4:0] corr_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  cdma_despreader dut (
    .clk_i(clk), .rst_i(rst), .seed_i(seed), .chip_i(chip),
    .chip_valid_i(chip_valid), .bit_o(bit_o), .bit_valid_o(bit_valid_o),
    .locked_o(locked_o), .corr_o(corr_o), .seed_err_o(seed_err_o),
    .state_o(state_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int corr_log[$];
  int bit_log[$];
  int c0 = 0, b0 = 0;
  int tx_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Gold chip n of the code for a seed, from the two sequence recurrences.
  function automatic logic gold_chip(input logic [4:0] s, input int idx);
    logic sa[36];
    logic sb[36];
    int   n;
    n = idx % 31;
    for (int i = 0; i < 5; i++) begin
      sa[i] = s[4-i];
      sb[i] = s[4-i];
    end
    for (int i = 5; i <= n; i++) begin
      sa[i] = sa[i-5] ^ sa[i-4] ^ sa[i-3] ^ sa[i-2];
      sb[i] = sb[i-5] ^ sb[i-2];
    end
    return sa[n] ^ sb[n];
  endfunction

  function automatic int corr_at(input int i);
    return (c0 + i < corr_log.size()) ? corr_log[c0 + i] : -1;
  endfunction

  function automatic int bit_at(input int i);
    return (b0 + i < bit_log.size()) ? bit_log[b0 + i] : -1;
  endfunction

  // ---------------- model + compare ----------------
  logic       s_rst = 1'b0, s_valid = 1'b0, s_chip = 1'b0;
  logic [4:0] s_seed = 5'd0;

  always @(posedge clk) begin
    s_rst   <= rst;
    s_valid <= chip_valid;
    s_chip  <= chip;
    s_seed  <= seed;
  end

  int         m_mode, m_phase, m_pos, m_sum, m_hits, m_misses, e_corr;
  logic [4:0] m_seed;
  logic       m_live = 1'b0, m_eval, is_hit, advance;
  logic       e_bit, e_bv, e_lock, e_serr;

  always @(negedge clk) begin
    m_eval = 1'b0;
    if (s_rst) begin
      m_live   = 1'b1;
      m_seed   = s_seed;
      m_mode   = (s_seed == 5'd0) ? M_IDLE : M_SEARCH;
      m_phase  = 0; m_pos = 0; m_sum = 0; m_hits = 0; m_misses = 0;
      e_bit    = 1'b0; e_bv = 1'b0; e_lock = 1'b0; e_corr = 0;
      e_serr   = (s_seed == 5'd0);
    end else if (m_live) begin
      e_bv = 1'b0;
      if (s_valid && m_mode != M_IDLE) begin
        m_sum += (s_chip != gold_chip(m_seed, m_phase)) ? 1 : 0;
        if (m_pos == 30) begin
          m_eval  = 1'b1;
          e_corr  = m_sum;
          is_hit  = (m_sum >= 27) || (m_sum <= 4);
          advance = 1'b1;
          if (m_mode == M_SEARCH) begin
            if (is_hit) begin
              m_hits++;
              if (m_hits == 2) begin
                m_mode = M_TRACK; m_misses = 0; e_bv = 1'b1; e_bit = (m_sum >= 27);
              end
            end else begin
              m_hits = 0; advance = 1'b0;
            end
          end else begin
            e_bv  = 1'b1;
            e_bit = is_hit ? (m_sum >= 27) : (m_sum >= 16);
            if (is_hit) m_misses = 0;
            else begin
              m_misses++;
              if (m_misses == 3) begin m_mode = M_SEARCH; m_hits = 0; end
            end
          end
          m_pos = 0; m_sum = 0;
          if (advance) m_phase++;
        end else begin
          m_pos++; m_phase++;
        end
      end
      e_lock = (m_mode == M_TRACK);
    end
    if (m_live) begin
      check("outputs", int'({bit_valid_o, bit_o, locked_o, seed_err_o, corr_o}),
            int'({e_bv, e_bit, e_lock, e_serr, 5'(e_corr)}));
      if (m_eval) corr_log.push_back(int'(corr_o));
      if (bit_valid_o) bit_log.push_back(int'(bit_o));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    chip_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic put_chip(input logic c, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    chip       = c;
    chip_valid = 1'b1;
    @(negedge clk);
    chip_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit inv, input bit gaps, input int n);
    for (int k = 0; k < n; k++) begin
      put_chip(b ^ gold_chip(TX_SEED, tx_idx) ^ (inv && (k % 8 == 3)), gaps);
      tx_idx++;
    end
  endtask

  task automatic do_reset(input logic [4:0] s);
    rst        = 1'b1;
    seed       = s;
    chip_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    c0     = corr_log.size();
    b0     = bit_log.size();
    tx_idx = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [30:0] gv;
    int t1c[4] = '{31, 0, 31, 31};
    int t1b[3] = '{0, 1, 1};
    int t4d[6] = '{1, 0, 1, 1, 0, 1};
    int t4c[6] = '{27, 4, 27, 27, 4, 27};
    int t4b[5] = '{0, 1, 1, 0, 1};
    int pat[4] = '{1, 0, 1, 1};
    int n, cnt;

    // 1: aligned stream 1,0,1,1
    do_reset(TX_SEED);
    for (int k = 0; k < 31; k++) gv[k] = gold_chip(TX_SEED, k);
    check("gold_seq", int'(gv), 32'h547A1460);
    check("rst_outs", int'({bit_o, bit_valid_o, locked_o, seed_err_o, corr_o}), 0);
    for (int i = 0; i < 4; i++) send_bit(1'(pat[i]), 1'b0, 1'b0, 31);
    idle(3);
    check("t1_ncorr", corr_log.size() - c0, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_corr%0d", i), corr_at(i), t1c[i]);
    check("t1_nbits", bit_log.size() - b0, 3);
    for (int i = 0; i < 3; i++) check($sformatf("t1_bit%0d", i), bit_at(i), t1b[i]);
    check("t1_lock", int'(locked_o), 1);

    // 3: loss of signal while locked
    n = bit_log.size();
    for (int i = 0; i < 93; i++) put_chip(1'($urandom_range(0, 1)), 1'b0);
    idle(3);
    check("t3_strobes", bit_log.size() - n, 3);
    check("t3_lock", int'(locked_o), 0);

    // 2: stream delayed by 5 chips
    do_reset(TX_SEED);
    for (int i = 0; i < 5; i++) put_chip(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 1'b0, 31);
    idle(3);
    cnt = 0;
    for (int i = 0; i < 5; i++) if (corr_at(i) > 4 && corr_at(i) < 27) cnt++;
    check("t2_slips", cnt, 5);
    check("t2_corr5", corr_at(5), 31);
    check("t2_corr6", corr_at(6), 31);
    check("t2_nbits", bit_log.size() - b0, 4);
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += bit_at(i);
    check("t2_ones", cnt, 4);
    check("t2_lock", int'(locked_o), 1);

    // 4: 4 inverted chips per period
    do_reset(TX_SEED);
    for (int i = 0; i < 6; i++) send_bit(1'(t4d[i]), 1'b1, 1'b0, 31);
    idle(3);
    for (int i = 0; i < 6; i++) check($sformatf("t4_corr%0d", i), corr_at(i), t4c[i]);
    for (int i = 0; i < 5; i++) check($sformatf("t4_bit%0d", i), bit_at(i), t4b[i]);
    check("t4_lock", int'(locked_o), 1);

    // 5: zero seed
    do_reset(5'd0);
    for (int i = 0; i < 200; i++) put_chip(1'($urandom_range(0, 1)), 1'b0);
    idle(3);
    check("t5_nbits", bit_log.size() - b0, 0);
    check("t5_serr", int'(seed_err_o), 1);
    check("t5_lock", int'(locked_o), 0);

    // 6: gapped stream, reset mid-period 10, reacquire
    do_reset(TX_SEED);
    for (int i = 0; i < 9; i++) send_bit(1'(pat[i % 4]), 1'b0, 1'b1, 31);
    send_bit(1'(pat[1]), 1'b0, 1'b1, 15);
    for (int i = 0; i < 4; i++) check($sformatf("t6_corr%0d", i), corr_at(i), t1c[i]);
    for (int i = 0; i < 3; i++) check($sformatf("t6_bit%0d", i), bit_at(i), t1b[i]);
    do_reset(TX_SEED);
    check("t6_rst_outs", int'({bit_o, bit_valid_o, locked_o, seed_err_o, corr_o}), 0);
    for (int i = 0; i < 4; i++) send_bit(1'(pat[i]), 1'b0, 1'b1, 31);
    idle(3);
    for (int i = 0; i < 3; i++) check($sformatf("t6_rebit%0d", i), bit_at(i), t1b[i]);
    check("t6_lock", int'(locked_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
